// File: rtl/random_range_gen.sv
// random_range_gen: LFSR generator with bounded [0, limit) draws over valid/ready (clk, rst active-low async, en, seed_load/seed, req/limit, busy, valid/ready, random_num, lfsr_state)
module random_range_gen #(
  parameter int WIDTH = 12,
  parameter logic [WIDTH-1:0] TAPS = 12'h053,
  parameter logic [WIDTH-1:0] RESET_SEED = 12'hACE,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] random_num,
  output logic [WIDTH-1:0] lfsr_state
);
  localparam int TW = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;
  localparam logic [WIDTH-1:0] SEED0 = RESET_SEED == '0 ? WIDTH'(1) : RESET_SEED;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_lfsr, r_num, r_lim, w_step, w_lm1, w_mask, w_cand, w_fall;
  logic [TW-1:0] r_tries;
  logic r_valid, r_busy, w_accept, w_last;
  always_comb begin
    w_step = r_lfsr == '0 ? WIDTH'(1) : {^(r_lfsr & TAPS), r_lfsr[WIDTH-1:1]};
    w_lm1 = r_lim - WIDTH'(1);
    w_mask = '0;
    // bit i is set when any bit of lim-1 at or above i is set: smallest 2^k-1 >= lim-1
    for (int i = 0; i < WIDTH; i++) w_mask[i] = r_lim == '0 || (w_lm1 >> i) != '0;
    w_cand = r_lfsr & w_mask;
    w_accept = r_lim == '0 || w_cand < r_lim;
    w_last = r_tries == TW'(MAX_TRIES - 1);
    // cand <= 2*(lim-1), so one subtraction always lands inside [0, lim)
    w_fall = w_cand >= r_lim ? w_cand - r_lim : w_cand;
    w_next = r_state;
    if (r_state == IDLE) w_next = req ? DRAW : IDLE;
    if (r_state == DRAW) w_next = (w_accept || w_last) ? DONE : DRAW;
    if (r_state == DONE) w_next = ready ? IDLE : DONE;
    if (seed_load) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_lfsr <= SEED0;
      r_num <= '0;
      r_lim <= '0;
      r_tries <= '0;
      r_valid <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy <= w_next == DRAW;
      if (seed_load) begin
        r_lfsr <= seed == '0 ? WIDTH'(1) : seed;
        r_valid <= 1'b0;
        r_tries <= '0;
      end else begin
        if (r_state == DRAW || en) r_lfsr <= w_step;
        if (r_state == IDLE && req) begin
          r_lim <= limit;
          r_tries <= '0;
        end
        if (r_state == DRAW) begin
          if (w_accept || w_last) begin
            r_num <= w_accept ? w_cand : w_fall;
            r_valid <= 1'b1;
          end else r_tries <= r_tries + TW'(1);
        end
        if (r_state == DONE && ready) r_valid <= 1'b0;
      end
    end
  end
  assign busy = r_busy;
  assign valid = r_valid;
  assign random_num = r_num;
  assign lfsr_state = r_lfsr;
endmodule

// File: tb/tb_random_range_gen.sv
// tb_random_range_gen: directed and scoreboarded checks of random_range_gen
module tb_random_range_gen;
  logic clk = 1'b0;
  logic rst, en, seed_load, req, req2, ready;
  logic [11:0] seed, limit;
  logic busy, valid, busy2, valid2;
  logic [11:0] num, lfsr, num2, lfsr2;
  int n_vec = 0, n_err = 0;
  logic [11:0] q[$];
  always #5 clk = ~clk;
  random_range_gen dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed), .req(req), .limit(limit),
    .busy(busy), .valid(valid), .ready(ready), .random_num(num), .lfsr_state(lfsr)
  );
  random_range_gen #(.MAX_TRIES(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed), .req(req2), .limit(limit),
    .busy(busy2), .valid(valid2), .ready(ready), .random_num(num2), .lfsr_state(lfsr2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] mstep(input logic [11:0] l);
    return l == 12'h000 ? 12'h001 : {^(l & 12'h053), l[11:1]};
  endfunction
  task automatic mdraw(input logic [11:0] s, input logic [11:0] lim, input int mt,
                       output logic [11:0] v, output int lat);
    int li, m;
    logic [11:0] l, c;
    li = lim;
    m = 0;
    if (li == 0) m = 4095;
    else while (m < li - 1) m = m * 2 + 1;
    l = s;
    v = 0;
    lat = 0;
    for (int t = 0; t < mt; t++) begin
      c = l & 12'(m);
      if (li == 0 || int'(c) < li) begin v = c; lat = 2 + t; break; end
      if (t == mt - 1) begin v = int'(c) >= li ? 12'(int'(c) - li) : c; lat = 2 + t; break; end
      l = mstep(l);
    end
  endtask
  task automatic draw(input bit d2, input logic [11:0] s, input logic [11:0] lim, input int hold,
                      output logic [11:0] got);
    logic [11:0] mv;
    int ml, n, nb;
    seed_load = 1'b1;
    seed = s;
    tick;
    seed_load = 1'b0;
    mdraw(s == 12'h000 ? 12'h001 : s, lim, d2 ? 1 : 8, mv, ml);
    q.push_back(mv);
    limit = lim;
    if (d2) req2 = 1'b1; else req = 1'b1;
    tick;
    req = 1'b0;
    req2 = 1'b0;
    limit = ~lim;
    n = 1;
    nb = d2 ? busy2 : busy;
    while (!(d2 ? valid2 : valid) && n < 40) begin
      tick;
      n++;
      nb += d2 ? busy2 : busy;
    end
    chk("latency", n, ml);
    chk("busy_cycles", nb, ml - 1);
    got = d2 ? num2 : num;
    chk("result", got, q.pop_front());
    if (lim != 12'h000) chk("in_range", got < lim, 1);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", d2 ? valid2 : valid, 1);
      chk("hold_num", d2 ? num2 : num, got);
    end
    ready = 1'b1;
    tick;
    ready = 1'b0;
    chk("valid_drop", d2 ? valid2 : valid, 0);
  endtask
  initial begin
    logic [11:0] got, prev, ml;
    int n, mp;
    bit zs;
    rst = 1'b0; en = 1'b0; seed_load = 1'b0; req = 1'b0; req2 = 1'b0; ready = 1'b0;
    seed = '0; limit = '0;
    tick;
    tick;
    chk("rst_lfsr", lfsr, 12'hACE);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_num", num, 0);
    rst = 1'b1;
    seed_load = 1'b1; seed = 12'h001;
    tick;
    seed_load = 1'b0;
    chk("step0", lfsr, 12'h001);
    en = 1'b1;
    tick; chk("step1", lfsr, 12'h800);
    tick; chk("step2", lfsr, 12'h400);
    tick; chk("step3", lfsr, 12'h200);
    en = 1'b0;
    seed_load = 1'b1; seed = 12'h000;
    tick;
    seed_load = 1'b0;
    chk("zero_seed", lfsr, 12'h001);
    ml = 12'h001;
    mp = 0;
    do begin ml = mstep(ml); mp++; end while (ml != 12'h001 && mp < 5000);
    en = 1'b1;
    n = 0;
    zs = 0;
    do begin
      tick;
      n++;
      if (lfsr == 12'h000) zs = 1;
    end while (lfsr != 12'h001 && n < 5000);
    en = 1'b0;
    chk("period", n, mp);
    chk("never_zero", zs, 0);
    draw(0, 12'h001, 12'h000, 5, got);
    chk("full_val", got, 12'h001);
    draw(0, 12'h003, 12'h003, 1, got);
    chk("reject_val", got, 12'h001);
    draw(1, 12'h003, 12'h003, 1, got);
    chk("fallback_val", got, 12'h000);
    draw(1, 12'($urandom), 12'h001, 0, got);
    chk("lim1_fb", got, 12'h000);
    draw(0, 12'($urandom), 12'h001, 0, got);
    chk("lim1", got, 12'h000);
    for (int i = 0; i < 6; i++)
      draw(0, 12'($urandom), i < 3 ? 12'($urandom_range(1, 20)) : 12'($urandom), 0, got);
    draw(1, 12'($urandom), 12'($urandom_range(1, 4095)), 0, got);
    prev = num;
    limit = 12'h003;
    req = 1'b1;
    tick;
    req = 1'b0;
    chk("abort_busy", busy, 1);
    seed_load = 1'b1; seed = 12'h5A5;
    tick;
    seed_load = 1'b0;
    chk("abort_valid", valid, 0);
    chk("abort_busy0", busy, 0);
    chk("abort_lfsr", lfsr, 12'h5A5);
    chk("abort_num", num, prev);
    tick;
    chk("abort_idle", busy, 0);
    seed_load = 1'b1; seed = 12'h001;
    tick;
    seed_load = 1'b0;
    limit = 12'h000;
    req = 1'b1;
    tick;
    req = 1'b0;
    tick;
    chk("done_valid", valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lfsr", lfsr, 12'hACE);
    chk("arst_num", num, 0);
    tick;
    rst = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
